// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration shift-chain loader.
package cfg_pkg;

  localparam int unsigned CFG_BYTE_W      = 8;
  localparam int unsigned SWITCH_CFG_BITS = 40;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SH_LO,
    SH_HI,
    DONE
  } cfg_state_e;

  // Number of whole configuration bytes needed to fill a chain of the given length.
  function automatic int unsigned chain_bytes(input int unsigned bits);
    return bits / CFG_BYTE_W;
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Host-side byte streams: configuration bytes in, displaced chain bytes back out.
interface cfg_chain_loader_if;
  import cfg_pkg::*;

  logic [CFG_BYTE_W-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [CFG_BYTE_W-1:0] out_data;
  logic                  out_valid;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid
  );

endinterface

// File: rtl/cfg_byte_shreg.sv
// Per-byte datapath: parallel-load/serial-out transmit byte with a bit index,
// and a serial-in/parallel-out readback byte filled MSB-first.
module cfg_byte_shreg
  import cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [CFG_BYTE_W-1:0] load_data,
  input  logic                  advance,
  input  logic                  sample,
  input  logic                  sin,
  output logic                  next_bit_c,
  output logic                  last_bit_c,
  output logic [CFG_BYTE_W-1:0] rx_byte
);

  localparam int unsigned IDX_W = $clog2(CFG_BYTE_W);

  logic [CFG_BYTE_W-1:0] tx_q;
  logic [IDX_W-1:0]      idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q    <= '0;
      idx_q   <= '0;
      rx_byte <= '0;
    end else begin
      if (load) begin
        tx_q  <= load_data;
        idx_q <= IDX_W'(CFG_BYTE_W - 1);
      end else if (advance) begin
        idx_q <= idx_q - IDX_W'(1);
      end
      if (sample) begin
        rx_byte <= {rx_byte[CFG_BYTE_W-2:0], sin};
      end
    end
  end

  // Bit that goes onto the chain at the next SH_LO entry: MSB of a fresh byte,
  // otherwise the bit below the one just clocked into the chain.
  assign next_bit_c = load ? load_data[CFG_BYTE_W-1] : tx_q[idx_q - IDX_W'(1)];
  assign last_bit_c = (idx_q == '0);

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises host configuration bytes into the switch-box shift chain and
// returns the displaced chain contents as a readback byte stream.
module cfg_chain_loader
  import cfg_pkg::*;
#(
  parameter int unsigned CHAIN_BITS = SWITCH_CFG_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  cfg_chain_loader_if.slave host,
  output logic              busy,
  output logic              done,
  output logic              shift_clk,
  output logic              shift_o,
  input  logic              shift_i
);

  localparam int unsigned N_BYTES = chain_bytes(CHAIN_BITS);
  localparam int unsigned CNT_W   = $clog2(N_BYTES + 1);

  cfg_state_e state_q;
  cfg_state_e state_d;

  logic [CNT_W-1:0]      byte_cnt_q;
  logic                  accept_c;
  logic                  byte_end_c;
  logic                  cnt_clr_c;
  logic                  last_byte_c;
  logic                  advance_c;
  logic                  sample_c;
  logic                  next_bit_c;
  logic                  last_bit_c;
  logic [CFG_BYTE_W-1:0] rx_byte;

  assign last_byte_c = (byte_cnt_q == CNT_W'(N_BYTES - 1));
  assign advance_c   = (state_q == SH_HI);
  assign sample_c    = (state_q == SH_LO);

  cfg_byte_shreg u_shreg (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_c),
    .load_data  (host.in_data),
    .advance    (advance_c),
    .sample     (sample_c),
    .sin        (shift_i),
    .next_bit_c (next_bit_c),
    .last_bit_c (last_bit_c),
    .rx_byte    (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    byte_end_c = 1'b0;
    cnt_clr_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr_c = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (host.in_valid) begin
          accept_c = 1'b1;
          state_d  = SH_LO;
        end
      end
      SH_LO: state_d = SH_HI;
      SH_HI: begin
        if (last_bit_c) begin
          byte_end_c = 1'b1;
          state_d    = last_byte_c ? DONE : LOAD;
        end else begin
          state_d = SH_LO;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Completed-byte counter; selects the DONE exit after the final byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
    end else if (cnt_clr_c) begin
      byte_cnt_q <= '0;
    end else if (byte_end_c) begin
      byte_cnt_q <= byte_cnt_q + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so each one lines up with the
  // state it belongs to; shift_o only moves on entry to SH_LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      host.in_ready  <= 1'b0;
      host.out_valid <= 1'b0;
      host.out_data  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      shift_clk      <= 1'b0;
      shift_o        <= 1'b0;
    end else begin
      host.in_ready  <= (state_d == LOAD);
      host.out_valid <= byte_end_c;
      busy           <= (state_d != IDLE);
      done           <= (state_d == DONE);
      shift_clk      <= (state_d == SH_HI);
      if (byte_end_c) begin
        host.out_data <= rx_byte;
      end
      if (state_d == SH_LO) begin
        shift_o <= next_bit_c;
      end
    end
  end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench: one 40-bit cell loader and one 80-bit two-cell loader with chain models.
module tb_cfg_chain_loader;
  import cfg_pkg::*;

  localparam int unsigned BITS_A = SWITCH_CFG_BITS;
  localparam int unsigned BITS_B = 2 * SWITCH_CFG_BITS;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       start_a  = 1'b0;
  logic       start_b  = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;

  logic busy_a, done_a, shift_clk_a, shift_o_a, shift_i_a;
  logic busy_b, done_b, shift_clk_b, shift_o_b, shift_i_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int edges_a = 0;
  int edges_b = 0;
  int stall_bad = 0;

  logic [7:0]  rb_a[$];
  logic [7:0]  rb_b[$];
  logic [39:0] cell_a  = '0;
  logic [39:0] cell_b0 = '0;
  logic [39:0] cell_b1 = '0;

  cfg_chain_loader_if ifa ();
  cfg_chain_loader_if ifb ();

  assign ifa.in_data  = in_data;
  assign ifa.in_valid = in_valid;
  assign ifb.in_data  = in_data;
  assign ifb.in_valid = in_valid;

  cfg_chain_loader #(.CHAIN_BITS(BITS_A)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (start_a),
    .host      (ifa),
    .busy      (busy_a),
    .done      (done_a),
    .shift_clk (shift_clk_a),
    .shift_o   (shift_o_a),
    .shift_i   (shift_i_a)
  );

  cfg_chain_loader #(.CHAIN_BITS(BITS_B)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (start_b),
    .host      (ifb),
    .busy      (busy_b),
    .done      (done_b),
    .shift_clk (shift_clk_b),
    .shift_o   (shift_o_b),
    .shift_i   (shift_i_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Chain models: bit shifted in first ends at data[39] of the farthest cell.
  always @(posedge shift_clk_a) begin
    cell_a <= {cell_a[38:0], shift_o_a};
    edges_a++;
  end
  assign shift_i_a = cell_a[39];

  always @(posedge shift_clk_b) begin
    cell_b0 <= {cell_b0[38:0], shift_o_b};
    cell_b1 <= {cell_b1[38:0], cell_b0[39]};
    edges_b++;
  end
  assign shift_i_b = cell_b1[39];

  always @(negedge clk) begin
    if (ifa.out_valid === 1'b1) rb_a.push_back(ifa.out_data);
    if (ifb.out_valid === 1'b1) rb_b.push_back(ifb.out_data);
    if (ifa.in_ready === 1'b1 && shift_clk_a !== 1'b0) stall_bad++;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit use_b);
    return use_b ? ifb.in_ready : ifa.in_ready;
  endfunction

  function automatic logic dn(input bit use_b);
    return use_b ? done_b : done_a;
  endfunction

  function automatic logic bz(input bit use_b);
    return use_b ? busy_b : busy_a;
  endfunction

  function automatic logic [79:0] rb_word(input bit use_b, input int base, input int n);
    logic [79:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[71:0], (use_b ? rb_b[base + i] : rb_a[base + i])};
    end
    return r;
  endfunction

  // Present one byte after an optional idle gap and hold it until accepted.
  task automatic feed_byte(input bit use_b, input logic [7:0] b, input int gap);
    int waited = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (rdy(use_b) !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) check("in_ready_timeout", 80'(rdy(use_b)), 80'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full load; latency is the cycle of done minus the cycle start was accepted.
  task automatic run_load(input bit use_b, input logic [79:0] data, input int n,
                          input int max_gap, output int latency);
    int waited = 0;
    int t0;
    int gap;
    in_valid = 1'b0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (max_gap == 0) gap = 0;
      else if (i == 0) gap = max_gap;
      else gap = int'($urandom_range(32'(max_gap), 0));
      feed_byte(use_b, data[8*(n-1-i) +: 8], gap);
    end
    while (dn(use_b) !== 1'b1 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) check("done_timeout", 80'(dn(use_b)), 80'd1);
    latency = cyc + 1 - t0;
    check("busy_during_done", 80'(bz(use_b)), 80'd1);
    @(negedge clk);
    check("done_one_cycle", 80'(dn(use_b)), 80'd0);
    check("busy_after_done", 80'(bz(use_b)), 80'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int e0;
    int b0;
    int s0;
    int w;

    // Reset held for two cycles with start asserted
    rst = 1'b1; start_a = 1'b1; start_b = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  80'(ifa.in_ready),  80'd0);
    check("rst_out_valid", 80'(ifa.out_valid), 80'd0);
    check("rst_out_data",  80'(ifa.out_data),  80'h00);
    check("rst_busy",      80'(busy_a),        80'd0);
    check("rst_done",      80'(done_a),        80'd0);
    check("rst_shift_clk", 80'(shift_clk_a),   80'd0);
    check("rst_shift_o",   80'(shift_o_a),     80'd0);
    check("rst_busy_b",    80'(busy_b),        80'd0);
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0;
    e0 = edges_a;
    repeat (10) @(negedge clk);
    check("idle_no_shift_clk", 80'(edges_a - e0), 80'd0);
    check("idle_busy",         80'(busy_a),       80'd0);
    check("idle_in_ready",     80'(ifa.in_ready), 80'd0);

    // First load into a zeroed cell, no stalls
    e0 = edges_a; b0 = rb_a.size();
    run_load(1'b0, 80'hA53CFF0081, 5, 0, lat);
    check("load1_cell",      80'(cell_a),             80'hA53CFF0081);
    check("load1_rb_count",  80'(rb_a.size() - b0),   80'd5);
    check("load1_rb_bytes",  rb_word(1'b0, b0, 5),    80'h0);
    check("load1_latency",   80'(lat),                80'd86);
    check("load1_sclk_edges",80'(edges_a - e0),       80'd40);
    check("load1_sclk_idle", 80'(shift_clk_a),        80'd0);

    // Reload returns the previous configuration
    e0 = edges_a; b0 = rb_a.size();
    run_load(1'b0, 80'h1122334455, 5, 0, lat);
    check("load2_cell",      80'(cell_a),             80'h1122334455);
    check("load2_rb_count",  80'(rb_a.size() - b0),   80'd5);
    check("load2_rb_bytes",  rb_word(1'b0, b0, 5),    80'hA53CFF0081);
    check("load2_latency",   80'(lat),                80'd86);

    // Host stalls between bytes
    e0 = edges_a; b0 = rb_a.size(); s0 = stall_bad;
    run_load(1'b0, 80'hA53CFF0081, 5, 20, lat);
    check("stall_cell",       80'(cell_a),            80'hA53CFF0081);
    check("stall_rb_count",   80'(rb_a.size() - b0),  80'd5);
    check("stall_rb_bytes",   rb_word(1'b0, b0, 5),   80'h1122334455);
    check("stall_sclk_edges", 80'(edges_a - e0),      80'd40);
    check("stall_sclk_low",   80'(stall_bad - s0),    80'd0);

    // Ignored start mid-load, then reset after two bytes
    b0 = rb_a.size();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    feed_byte(1'b0, 8'h11, 0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_ign_busy",  80'(busy_a),       80'd1);
    check("start_ign_shift", 80'(ifa.in_ready), 80'd0);
    feed_byte(1'b0, 8'h22, 0);
    w = 0;
    while (ifa.in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_ign_load",  80'(ifa.in_ready),      80'd1);
    check("start_ign_sclk",  80'(shift_clk_a),       80'd0);
    check("abort_rb_count",  80'(rb_a.size() - b0),  80'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",      80'(busy_a),        80'd0);
    check("abort_in_ready",  80'(ifa.in_ready),  80'd0);
    check("abort_sclk",      80'(shift_clk_a),   80'd0);
    check("abort_out_valid", 80'(ifa.out_valid), 80'd0);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", 80'(busy_a), 80'd0);
    run_load(1'b0, 80'hDEADBEEF42, 5, 0, lat);
    check("abort_reload_cell",    80'(cell_a), 80'hDEADBEEF42);
    check("abort_reload_latency", 80'(lat),    80'd86);

    // Two chained cells, 80-bit chain
    e0 = edges_b; b0 = rb_b.size();
    run_load(1'b1, 80'h0102030405060708090A, 10, 0, lat);
    check("b_near_cell",   80'(cell_b0),          80'h060708090A);
    check("b_far_cell",    80'(cell_b1),          80'h0102030405);
    check("b_latency",     80'(lat),              80'd171);
    check("b_sclk_edges",  80'(edges_b - e0),     80'd80);
    check("b_rb_count",    80'(rb_b.size() - b0), 80'd10);
    check("b_rb_bytes",    rb_word(1'b1, b0, 10), 80'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
